// File: rtl/instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// instr_mem_ctrl
//
// Instruction memory for the pipelined MIPS core with a built-in program
// loader. The debug unit streams program words in over a valid/ready
// handshake; a three-state controller (IDLE / LOAD / READY) tracks the load
// and only opens instruction fetch once a complete program is present. The
// IF stage then reads one word per cycle with a registered output, an
// out-of-range flag and optional per-word parity protection.
//
// Optional feature macro: IMEM_PARITY_EN
//   defined   -> each word carries an even-parity bit, checked on fetch
//   undefined -> no parity storage, parity_err is tied low
//
// Parameters:
//   DATA_W  instruction word width
//   DEPTH   number of words (power of two, 2..4096)
//   ADDR_W  log2(DEPTH)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   fetch_en     IF stage requests a word
//   fetch_addr   word address (PC>>2)
//   instr        fetched instruction (holds between fetches)
//   instr_valid  instr was updated this cycle
//   addr_err     the word on instr came from an address >= DEPTH
//   ld_start     pulse: begin a new program load
//   ld_valid     ld_data holds a program word
//   ld_data      program word
//   ld_last      marks the final word of the program
//   ld_ready     loader accepts a word this cycle
//   ld_done      one-cycle pulse when a load completes
//   ld_count     number of words written by the last load
//   ld_par_flip  inverts the stored parity bit of the accepted word
//   parity_err   parity mismatch on the word now on instr
//   ready        program loaded, fetch enabled
// ---------------------------------------------------------------------------
module instr_mem_ctrl #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic [31:0]       fetch_addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_err,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_done,
   output logic [ADDR_W:0]   ld_count,
   input  logic              ld_par_flip,
   output logic              parity_err,
   output logic              ready
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY
   } state_t;

   state_t state;
   state_t state_next;

   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] fetch_idx;
   logic              accept;
   logic              last_word;
   logic              fetch_hit;
   logic              out_of_range;
   logic              par_mismatch;

   // Handshake and fetch qualifiers. A load word completes the program either
   // because the streamer marks it last or because it fills the final slot.
   // A fetch that coincides with a reload request is dropped, since the
   // controller is leaving READY on that same edge.
   assign accept       = ld_valid & ld_ready;
   assign last_word    = ld_last | (ptr == ADDR_W'(DEPTH - 1));
   assign fetch_hit    = (state == READY) & fetch_en & ~ld_start;
   assign fetch_idx    = fetch_addr[ADDR_W-1:0];
   assign out_of_range = (fetch_addr >= 32'(DEPTH));

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. ld_start is ignored while a load is in progress.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ld_start) state_next = LOAD;
         LOAD:    if (accept && last_word) state_next = READY;
         READY:   if (ld_start) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   // Controller outputs are pure decodes of the state, so ld_ready rises the
   // cycle after ld_start and drops the cycle after the final accept.
   always_comb begin
      ld_ready = (state == LOAD);
      ready    = (state == READY);
   end

   // Loader bookkeeping: write pointer, word count and the completion pulse.
   // Starting a load (from IDLE or READY) rewinds both pointer and count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         ld_count <= '0;
         ld_done  <= 1'b0;
      end else begin
         ld_done <= accept & last_word;
         if (state != LOAD && ld_start) begin
            ptr      <= '0;
            ld_count <= '0;
         end else if (accept) begin
            ptr      <= ptr + ADDR_W'(1);
            ld_count <= ld_count + (ADDR_W + 1)'(1);
         end
      end
   end

   // Program storage. Deliberately outside the reset domain: a reset during
   // a load must leave previously written words intact.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[ptr] <= ld_data;
      end
   end

`ifdef IMEM_PARITY_EN
   logic mem_par [DEPTH];

   // Even-parity bit stored alongside each word; ld_par_flip lets a test
   // deliberately plant a corrupted parity bit.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_par[ptr] <= (^ld_data) ^ ld_par_flip;
      end
   end

   assign par_mismatch = (^mem[fetch_idx]) ^ mem_par[fetch_idx];
`else
   logic unused_par_flip;

   assign unused_par_flip = ld_par_flip;
   assign par_mismatch    = 1'b0;
`endif

   // Registered fetch port. instr only changes on an honoured fetch; the
   // status flags are single-cycle and describe the word just delivered.
   // Out-of-range fetches return a NOP (all zeros) rather than an aliased word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr       <= '0;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
         parity_err  <= 1'b0;
      end else begin
         instr_valid <= fetch_hit;
         addr_err    <= fetch_hit & out_of_range;
         parity_err  <= fetch_hit & ~out_of_range & par_mismatch;
         if (fetch_hit) begin
            instr <= out_of_range ? '0 : mem[fetch_idx];
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_ctrl
//
// Directed, self-checking bench for instr_mem_ctrl with default parameters
// (DATA_W=32, DEPTH=64). Each task drives one scenario and compares the DUT
// outputs against hand-computed values. Parity scenarios are compiled in
// only when IMEM_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_instr_mem_ctrl;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk;
   logic              rst;
   logic              fetch_en;
   logic [31:0]       fetch_addr;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              addr_err;
   logic              ld_start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              ld_done;
   logic [ADDR_W:0]   ld_count;
   logic              ld_par_flip;
   logic              parity_err;
   logic              ready;

   int checks;
   int failures;

   logic [31:0] prog_a [4];
   logic [31:0] prog_b [4];

   instr_mem_ctrl #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_en   (fetch_en),
      .fetch_addr (fetch_addr),
      .instr      (instr),
      .instr_valid(instr_valid),
      .addr_err   (addr_err),
      .ld_start   (ld_start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .ld_done    (ld_done),
      .ld_count   (ld_count),
      .ld_par_flip(ld_par_flip),
      .parity_err (parity_err),
      .ready      (ready)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it; inputs change and
   // outputs are sampled here, away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_en = 1'b0; fetch_addr = '0; ld_start = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ld_par_flip = 1'b0;
      #2;
      checks++;
      if ({instr_valid, addr_err, ld_ready, ld_done, ready, parity_err} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got=%b exp=000000",
                  {instr_valid, addr_err, ld_ready, ld_done, ready, parity_err});
      end
      checks++;
      if (instr !== 32'h0 || ld_count !== 7'd0) begin
         failures++;
         $display("[TB] FAIL reset_values instr=%h ld_count=%0d exp instr=0 ld_count=0", instr, ld_count);
      end
      tick();
      tick();
      rst = 1'b0;
      fetch_en = 1'b1; fetch_addr = 32'd0;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_blocks_fetch instr_valid=%b ready=%b exp 0 0", instr_valid, ready);
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_load4();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      checks++;
      if (ld_ready !== 1'b1 || ld_count !== 7'd0) begin
         failures++;
         $display("[TB] FAIL load4_start ld_ready=%b ld_count=%0d exp 1 0", ld_ready, ld_count);
      end
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = prog_a[i]; ld_last = (i == 3);
         tick();
         checks++;
         if (ld_count !== 7'(i + 1)) begin
            failures++;
            $display("[TB] FAIL load4_count word=%0d got=%0d exp=%0d", i, ld_count, i + 1);
         end
         checks++;
         if ({ld_ready, ld_done, ready} !== ((i == 3) ? 3'b011 : 3'b100)) begin
            failures++;
            $display("[TB] FAIL load4_flags word=%0d got=%b exp=%b", i,
                     {ld_ready, ld_done, ready}, (i == 3) ? 3'b011 : 3'b100);
         end
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      checks++;
      if ({ld_ready, ld_done, ready} !== 3'b001 || ld_count !== 7'd4) begin
         failures++;
         $display("[TB] FAIL load4_done_pulse flags=%b count=%0d exp flags=001 count=4",
                  {ld_ready, ld_done, ready}, ld_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         fetch_en = 1'b1; fetch_addr = 32'(i);
         tick();
         checks++;
         if (instr !== prog_a[i] || {instr_valid, addr_err, parity_err} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL b2b_fetch addr=%0d instr=%h flags=%b exp instr=%h flags=100",
                     i, instr, {instr_valid, addr_err, parity_err}, prog_a[i]);
         end
      end
      fetch_en = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || instr !== prog_a[3]) begin
         failures++;
         $display("[TB] FAIL fetch_hold instr_valid=%b instr=%h exp 0 %h", instr_valid, instr, prog_a[3]);
      end
   endtask

   task automatic test_range();
      fetch_en = 1'b1; fetch_addr = 32'd64;
      tick();
      checks++;
      if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL range_64 instr=%h valid=%b err=%b exp 0 1 1", instr, instr_valid, addr_err);
      end
      fetch_addr = 32'd2;
      tick();
      checks++;
      if (instr !== prog_a[2] || instr_valid !== 1'b1 || addr_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL range_back_in instr=%h valid=%b err=%b exp %h 1 0",
                  instr, instr_valid, addr_err, prog_a[2]);
      end
      fetch_addr = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (instr !== 32'h0 || addr_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL range_max instr=%h err=%b exp 0 1", instr, addr_err);
      end
      fetch_addr = 32'd2;
      tick();
      fetch_en = 1'b0;
   endtask

   task automatic test_full_load();
      // Reload request with a fetch in the same cycle: the fetch is dropped.
      ld_start = 1'b1; fetch_en = 1'b1; fetch_addr = 32'd0;
      tick();
      ld_start = 1'b0; fetch_en = 1'b0;
      checks++;
      if ({instr_valid, ld_ready, ready} !== 3'b010 || instr !== prog_a[2]) begin
         failures++;
         $display("[TB] FAIL reload_drops_fetch flags=%b instr=%h exp flags=010 instr=%h",
                  {instr_valid, ld_ready, ready}, instr, prog_a[2]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1'b1; ld_data = 32'h1000_0000 | 32'(i); ld_last = 1'b0;
         tick();
         checks++;
         if ({ld_ready, ld_done, ready} !== ((i == DEPTH - 1) ? 3'b011 : 3'b100) ||
             ld_count !== 7'(i + 1)) begin
            failures++;
            $display("[TB] FAIL full_load word=%0d flags=%b count=%0d exp flags=%b count=%0d",
                     i, {ld_ready, ld_done, ready}, ld_count,
                     (i == DEPTH - 1) ? 3'b011 : 3'b100, i + 1);
         end
      end
      ld_valid = 1'b0;
      tick();
      checks++;
      if (ld_count !== 7'd64 || ld_done !== 1'b0 || ld_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_load_end count=%0d done=%b ld_ready=%b exp 64 0 0",
                  ld_count, ld_done, ld_ready);
      end
      foreach (prog_b[k]) begin
         fetch_en = 1'b1;
         fetch_addr = (k == 0) ? 32'd0 : (k == 1) ? 32'd37 : (k == 2) ? 32'd63 : 32'd5;
         tick();
         checks++;
         if (instr !== (32'h1000_0000 | fetch_addr) || instr_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_load_fetch addr=%0d instr=%h valid=%b exp %h 1",
                     fetch_addr, instr, instr_valid, 32'h1000_0000 | fetch_addr);
         end
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_reset_midload();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_data = 32'hDEAD_0000 | 32'(i); ld_last = 1'b0;
         tick();
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({instr_valid, addr_err, ld_ready, ld_done, ready, parity_err} !== 6'b0 ||
          instr !== 32'h0 || ld_count !== 7'd0) begin
         failures++;
         $display("[TB] FAIL async_reset flags=%b instr=%h count=%0d exp 000000 0 0",
                  {instr_valid, addr_err, ld_ready, ld_done, ready, parity_err}, instr, ld_count);
      end
      tick();
      rst = 1'b0;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      checks++;
      if (ld_ready !== 1'b1 || ld_count !== 7'd0) begin
         failures++;
         $display("[TB] FAIL reload_start ld_ready=%b count=%0d exp 1 0", ld_ready, ld_count);
      end
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = prog_b[i]; ld_last = (i == 3);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++;
      if (ld_count !== 7'd4 || ready !== 1'b1 || ld_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reload_done count=%0d ready=%b done=%b exp 4 1 1", ld_count, ready, ld_done);
      end
      for (int i = 0; i < 5; i++) begin
         fetch_en = 1'b1; fetch_addr = 32'(i);
         tick();
         checks++;
         if (instr !== ((i < 4) ? prog_b[i] : 32'h1000_0004)) begin
            failures++;
            $display("[TB] FAIL reload_fetch addr=%0d got=%h exp=%h", i, instr,
                     (i < 4) ? prog_b[i] : 32'h1000_0004);
         end
      end
      fetch_en = 1'b0;
   endtask

`ifdef IMEM_PARITY_EN
   task automatic test_parity();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; ld_par_flip = 1'b1; ld_last = 1'b0;
      tick();
      ld_data = 32'h1234_5678; ld_par_flip = 1'b0; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      fetch_en = 1'b1; fetch_addr = 32'd0;
      tick();
      checks++;
      if (parity_err !== 1'b1 || instr !== 32'hFFFF_FFFF || instr_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL parity_flipped perr=%b instr=%h valid=%b exp 1 ffffffff 1",
                  parity_err, instr, instr_valid);
      end
      fetch_addr = 32'd1;
      tick();
      checks++;
      if (parity_err !== 1'b0 || instr !== 32'h1234_5678) begin
         failures++;
         $display("[TB] FAIL parity_clean perr=%b instr=%h exp 0 12345678", parity_err, instr);
      end
      fetch_en = 1'b0;
      tick();
      checks++;
      if (parity_err !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL parity_idle perr=%b valid=%b exp 0 0", parity_err, instr_valid);
      end
   endtask
`endif

   // Scenario sequence.
   initial begin
      checks = 0;
      failures = 0;
      prog_a[0] = 32'h2001_0005; prog_a[1] = 32'h2002_0007;
      prog_a[2] = 32'h0022_1820; prog_a[3] = 32'hAC03_0000;
      prog_b[0] = 32'h0BAD_F00D; prog_b[1] = 32'h8C01_0004;
      prog_b[2] = 32'h1022_FFFE; prog_b[3] = 32'h0000_0000;
      test_reset();
      test_load4();
      test_back_to_back();
      test_range();
      test_full_load();
      test_reset_midload();
`ifdef IMEM_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
